// File: rtl/sms_trigger_pkg.sv
// Shared constants and the per-stage action encoding for the SDTRL trigger chain.
package sms_trigger_pkg;

    localparam int WIDTH_MAX = 16;
    localparam logic [WIDTH_MAX-1:0] RESET_VAL_DEF = '1;

    localparam logic [1:0] ACT_HOLD   = 2'd0;
    localparam logic [1:0] ACT_SET1   = 2'd1;
    localparam logic [1:0] ACT_SET0   = 2'd2;
    localparam logic [1:0] ACT_TOGGLE = 2'd3;

    // DC left beats DC right, left AC beats right AC, toggle is weakest.
    function automatic logic [1:0] stage_act(
        input logic dcl_n,
        input logic dcr_n,
        input logic left,
        input logic right,
        input logic tog
    );
        logic [1:0] a;
        a = ACT_HOLD;
        if (!dcl_n)      a = ACT_SET1;
        else if (!dcr_n) a = ACT_SET0;
        else if (left)   a = ACT_SET0;
        else if (right)  a = ACT_SET1;
        else if (tog)    a = ACT_TOGGLE;
        return a;
    endfunction

    function automatic logic apply_act(input logic [1:0] a, input logic s);
        logic n;
        n = s;
        case (a)
            ACT_SET1:   n = 1'b1;
            ACT_SET0:   n = 1'b0;
            ACT_TOGGLE: n = ~s;
            default:    n = s;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sms_trigger_chain_if.sv
// Input/output bundle of the trigger chain: DC resets, gated AC pairs,
// toggle input and the stage outputs.
interface sms_trigger_chain_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] dcl_n;
    logic [WIDTH-1:0] dcr_n;
    logic [WIDTH-1:0] acl0;
    logic [WIDTH-1:0] acl1;
    logic [WIDTH-1:0] gl0;
    logic [WIDTH-1:0] gl1;
    logic [WIDTH-1:0] acr0;
    logic [WIDTH-1:0] acr1;
    logic [WIDTH-1:0] gr0;
    logic [WIDTH-1:0] gr1;
    logic             t;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] p;
    logic             co;

    modport master (
        output dcl_n, dcr_n, acl0, acl1, gl0, gl1,
        output acr0, acr1, gr0, gr1, t,
        input  b, p, co
    );

    modport slave (
        input  dcl_n, dcr_n, acl0, acl1, gl0, gl1,
        input  acr0, acr1, gr0, gr1, t,
        output b, p, co
    );
endinterface

// File: rtl/sms_edge_detect.sv
// Rising-edge detector sampled on the system clock; previous values reset
// to ones so a level held high through reset never reports an edge.
module sms_edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= '1;
        else     prev <= d;
    end

    assign rise = d & ~prev;
endmodule

// File: rtl/sms_trigger_chain.sv
// Bank of SDTRL trigger binaries with DC/AC priority mux and optional ripple
// carry chain, enabled by defining SMS_TRIGGER_CARRY_EN.
module sms_trigger_chain
    import sms_trigger_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = RESET_VAL_DEF[WIDTH-1:0]
) (
    input logic x,
    input logic rst,
    sms_trigger_chain_if.slave bus
);
    logic [WIDTH-1:0]   state;
    logic [WIDTH-1:0]   state_nx;
    logic [4*WIDTH-1:0] ac_in;
    logic [4*WIDTH-1:0] ac_rise;
    logic               t_rise;
    logic [WIDTH-1:0]   left;
    logic [WIDTH-1:0]   right;
    logic [WIDTH-1:0]   tog_en;

    assign ac_in = {bus.acr1, bus.acr0, bus.acl1, bus.acl0};

    sms_edge_detect #(.WIDTH(4*WIDTH)) u_ac_edge (
        .clk  (x),
        .rst  (rst),
        .d    (ac_in),
        .rise (ac_rise)
    );

    sms_edge_detect #(.WIDTH(1)) u_t_edge (
        .clk  (x),
        .rst  (rst),
        .d    (bus.t),
        .rise (t_rise)
    );

    always_comb begin
        left  = (ac_rise[WIDTH-1:0]         & bus.gl0)
              | (ac_rise[2*WIDTH-1:WIDTH]   & bus.gl1);
        right = (ac_rise[3*WIDTH-1:2*WIDTH] & bus.gr0)
              | (ac_rise[4*WIDTH-1:3*WIDTH] & bus.gr1);
    end

`ifdef SMS_TRIGGER_CARRY_EN
    // Enables come from pre-edge state so overrides never disturb carries.
    always_comb begin
        logic carry;
        tog_en = '0;
        carry  = t_rise;
        for (int i = 0; i < WIDTH; i++) begin
            tog_en[i] = carry;
            carry     = carry & state[i];
        end
    end

    logic co_q;

    always_ff @(posedge x or posedge rst) begin
        if (rst) co_q <= 1'b0;
        else     co_q <= t_rise & (&state);
    end

    assign bus.co = co_q;
`else
    assign tog_en = {WIDTH{t_rise}};
    assign bus.co = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        for (int i = 0; i < WIDTH; i++) begin
            state_nx[i] = apply_act(
                stage_act(bus.dcl_n[i], bus.dcr_n[i],
                          left[i], right[i], tog_en[i]),
                state[i]);
        end
    end

    always_ff @(posedge x or posedge rst) begin
        if (rst) state <= RESET_VAL;
        else     state <= state_nx;
    end

    assign bus.b = state;
    assign bus.p = ~state;
endmodule

// File: tb/tb_sms_trigger_chain.sv
// Table-driven bench for sms_trigger_chain with a scoreboard queue;
// expectations cover both builds, selected by SMS_TRIGGER_CARRY_EN.
module tb_sms_trigger_chain;
    localparam int W = 4;
`ifdef SMS_TRIGGER_CARRY_EN
    localparam bit CARRY = 1'b1;
`else
    localparam bit CARRY = 1'b0;
`endif

    typedef struct {
        logic [3:0] dcl_n, dcr_n;
        logic [3:0] acl0, gl0, acl1, gl1;
        logic [3:0] acr0, gr0, acr1, gr1;
        logic       t;
        logic [3:0] exp_c;
        logic [3:0] exp_n;
        logic       co_c;
    } vec_t;

    typedef struct {
        logic [3:0] b;
        logic       co;
        int         idx;
    } exp_t;

    logic x;
    logic rst;
    int   checks;
    int   failures;
    vec_t vecs[$];
    exp_t sb[$];

    sms_trigger_chain_if #(.WIDTH(W)) bus ();

    sms_trigger_chain #(.WIDTH(W)) dut (
        .x   (x),
        .rst (rst),
        .bus (bus)
    );

    initial x = 1'b0;
    always #5 x = ~x;

    task automatic chk(input string name, input int idx,
                       input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h required=%h",
                     name, idx, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.dcl_n = v.dcl_n;
        bus.dcr_n = v.dcr_n;
        bus.acl0  = v.acl0;
        bus.gl0   = v.gl0;
        bus.acl1  = v.acl1;
        bus.gl1   = v.gl1;
        bus.acr0  = v.acr0;
        bus.gr0   = v.gr0;
        bus.acr1  = v.acr1;
        bus.gr1   = v.gr1;
        bus.t     = v.t;
    endtask

    task automatic add(input logic [3:0] dl, input logic [3:0] dr,
                       input logic [3:0] al0, input logic [3:0] g0,
                       input logic [3:0] al1, input logic [3:0] g1,
                       input logic [3:0] ar0, input logic [3:0] h0,
                       input logic [3:0] ar1, input logic [3:0] h1,
                       input logic tt, input logic [3:0] ec,
                       input logic [3:0] en, input logic coc);
        vec_t v;
        v.dcl_n = dl;  v.dcr_n = dr;
        v.acl0  = al0; v.gl0   = g0;
        v.acl1  = al1; v.gl1   = g1;
        v.acr0  = ar0; v.gr0   = h0;
        v.acr1  = ar1; v.gr1   = h1;
        v.t     = tt;
        v.exp_c = ec;  v.exp_n = en;
        v.co_c  = coc;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t e;
        vec_t z;
        checks   = 0;
        failures = 0;

        //  dcl  dcr  acl0 gl0  acl1 gl1  acr0 gr0  acr1 gr1  t  carry nocar co
        add(4'hF,4'hF,4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'hF,4'hF,0);
        add(4'hF,4'hF,4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'hF,4'hF,0);
        add(4'hF,4'hF,4'h0,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'hF,4'hF,0);
        add(4'hF,4'hF,4'h4,4'h4,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'hB,4'hB,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'hB,4'hB,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h4,4'h0,0, 4'hB,4'hB,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'hB,4'hB,0);
        add(4'hF,4'hE,4'h0,4'h0,4'h0,4'h0,4'h1,4'h1,4'h0,4'h0,0, 4'hA,4'hA,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'hA,4'hA,0);
        add(4'hF,4'hD,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'h8,4'h8,0);
        add(4'hD,4'hD,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'hA,4'hA,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'hA,4'hA,0);
        add(4'hF,4'hF,4'h8,4'h8,4'h0,4'h0,4'h8,4'h8,4'h0,4'h0,0, 4'h2,4'h2,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'h2,4'h2,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h1,4'h0,4'h1,4'h1,0, 4'h3,4'h3,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'h3,4'h3,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h2,4'h2,4'h0,4'h0,4'h0,4'h0,0, 4'h1,4'h1,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'h1,4'h1,0);
        add(4'h5,4'hA,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'hA,4'hA,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'hA,4'hA,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,1, 4'hB,4'h5,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'hB,4'h5,0);
        add(4'h1,4'hE,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'hE,4'hE,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'hE,4'hE,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,1, 4'hF,4'h1,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'hF,4'h1,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,1, 4'h0,4'hE,1);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'h0,4'hE,0);
        add(4'h8,4'h7,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'h7,4'h7,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'h7,4'h7,0);
        add(4'hF,4'hE,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,1, 4'h8,4'h8,0);
        add(4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0, 4'h8,4'h8,0);

        // Reset with acl0 held high and gated.
        z = vecs[0];
        drive(z);
        rst = 1'b1;
        repeat (3) @(posedge x);
        #1;
        chk("reset_b", -1, bus.b, 4'hF);
        chk("reset_p", -1, bus.p, 4'h0);
        chk("reset_co", -1, {3'b0, bus.co}, 4'h0);
        @(negedge x);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge x);
            drive(vecs[i]);
            e.b   = CARRY ? vecs[i].exp_c : vecs[i].exp_n;
            e.co  = CARRY ? vecs[i].co_c : 1'b0;
            e.idx = i;
            sb.push_back(e);
            @(posedge x);
            #1;
            e = sb.pop_front();
            chk("b", e.idx, bus.b, e.b);
            chk("p", e.idx, bus.p, ~e.b);
            chk("co", e.idx, {3'b0, bus.co}, {3'b0, e.co});
        end

        // Reset asserted mid-cycle while t rises: pulse must be lost.
        @(negedge x);
        bus.t = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_b", -2, bus.b, 4'hF);
        chk("async_rst_co", -2, {3'b0, bus.co}, 4'h0);
        @(negedge x);
        rst = 1'b0;
        @(posedge x);
        #1;
        chk("t_held_b", -3, bus.b, 4'hF);
        chk("t_held_co", -3, {3'b0, bus.co}, 4'h0);
        @(negedge x);
        bus.t = 1'b0;
        @(posedge x);
        #1;
        chk("t_low_b", -4, bus.b, 4'hF);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sms_trigger_chain.md
# sms_trigger_chain

Parametrised bank of SDTRL trigger binaries for the 1620 logic reproduction, the multi-stage successor of the single TAJ trigger card. Each stage has DC set/reset, two gated AC set inputs per side, and a shared binary (toggle) input; the chain can be compiled as a ripple binary counter. It replaces hand-wired cascades of single-trigger cards in counters, scan registers and digit-position triggers. All AC inputs are edge-detected against the system clock rather than used as asynchronous clocks.

## Interface
- `WIDTH`, default 4: number of trigger stages (1..16).
- `RESET_VAL`, default all ones: state loaded by `rst` (matches the card power-on state of 1).
- `x` input 1: system clock, all state changes on rising edge.
- `rst` input 1: reset; asynchronous and active-high.
- `dcl_n` input WIDTH: DC reset-left per stage, active-low level, forces stage to 1.
- `dcr_n` input WIDTH: DC reset-right per stage, active-low level, forces stage to 0.
- `acl0`, `acl1` input WIDTH: left AC set pulses, rising-edge sensitive, force 0 when gated.
- `gl0`, `gl1` input WIDTH: left gates, level, qualify `acl0`/`acl1`.
- `acr0`, `acr1` input WIDTH: right AC set pulses, rising-edge sensitive, force 1 when gated.
- `gr0`, `gr1` input WIDTH: right gates, level, qualify `acr0`/`acr1`.
- `t` input 1: binary (toggle) input, rising-edge sensitive.
- `b` output WIDTH: stage state.
- `p` output WIDTH: complement of `b`.
- `co` output 1: carry-out pulse.

## Operation
- Edge detect: each AC input and `t` has a previous-value register; edge = current & ~previous, sampled at `x`. Previous registers reset to 1, so an input held high through reset never fires.
- Gate is sampled on the same `x` edge as the AC edge; gate low on that edge discards the pulse (no pending memory).
- Per-stage priority on each `x` edge, highest first:
  - `dcl_n`=0 -> 1;
  - `dcr_n`=0 -> 0;
  - left AC (`acl0` edge & `gl0`, or `acl1` edge & `gl1`) -> 0;
  - right AC (either gated pair) -> 1;
  - toggle -> ~state;
  - else hold.
- Both DC resets low: stage is 1. Simultaneous left and right AC: left wins (0).
- Toggle enable per stage is defined under Configuration. It is computed from pre-edge state, so a stage overridden by DC/AC does not alter carries to higher stages that cycle.
- `b` = state, `p` = ~state, both straight from flops.
- `rst` asserted: state = `RESET_VAL`, edge registers = all ones, `co` = 0 immediately. Reset mid-pulse: a pulse whose rising edge was before or during reset is lost.

## Timing
- AC/`t` to `b`/`p`: state changes on the first `x` edge that samples the input high after a low sample (0 extra cycles).
- Minimum pulse: one `x` period high, one `x` period low between pulses. Pulses shorter than one period may be missed.
- `co`: high exactly one cycle, registered. Set on the edge where a `t` edge meets all stages = 1 with all toggle enables applied (counter wraps to 0); low otherwise.
- DC resets are level: stage held while low, released on first edge after high.

## Configuration
- `SMS_TRIGGER_CARRY_EN` defined: ripple counter.
  - Stage i toggles when there is a `t` edge and stages 0..i-1 are all 1 (pre-edge).
  - A wrap from all ones to all zeros pulses `co`.
- Undefined:
  - A `t` edge complements every stage not overridden (ones' complement of the register).
  - `co` is tied 0.
  - No carry logic is synthesised.

## Structure
- Package `sms_trigger_pkg`:
  - `WIDTH_MAX` = 16;
  - default `RESET_VAL` constant;
  - localparam encoding of per-stage action (HOLD, SET1, SET0, TOGGLE) used by the priority mux.
- Sub-module `sms_edge_detect`: parametrised-width rising-edge detector with reset-to-ones previous registers. It is instantiated once for the 4×WIDTH AC inputs and once for `t`.
- Top holds the priority mux, the carry enable chain and the `co` register.

## Test plan
- Reset: assert `rst` with `acl0`=1111 held high; release -> `b`=1111, `p`=0000, and no state change on following edges while `acl0` stays high.
- Gated AC: `acl0[2]` rising with `gl0[2]`=1 -> `b`=1011 on that edge. Then `acr1[2]` rising with `gr1[2]`=0 -> `b` stays 1011.
- Priority: on the same edge, `dcr_n[0]`=0 and `acr0[0]` edge with gate -> `b[0]`=0. Both `dcl_n[1]` and `dcr_n[1]` low -> `b[1]`=1. Left and right AC edges together on stage 3 -> `b[3]`=0.
- Counter (CARRY_EN): from `b`=1110, pulse `t` twice -> `b`=1111 then 0000, with `co`=1 for exactly the cycle after the second `t` edge.
- Non-carry build: from `b`=1010, one `t` pulse -> `b`=0101, `co`=0.
- Toggle plus override (CARRY_EN): `b`=0111, `t` edge with `dcr_n[0]`=0 -> stage 0=0, stages 1,2 = 0, stage 3 = 1 (carries from pre-edge state), giving `b`=1000.
